// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial subtractor computing a - b - b_in, modulo 2^WIDTH.
//            The subtraction runs LSB first, one full-subtractor bit per clock.
//            Operands enter through a valid/ready handshake, and the result
//            leaves through a second valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   clock; all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   a, b and b_in are valid
//   in_ready  out  block is idle and can accept operands
//   a         in   [WIDTH] minuend
//   b         in   [WIDTH] subtrahend
//   b_in      in   borrow-in
//   out_valid out  diff, b_out and ovf are valid
//   out_ready in   consumer accepts the result
//   diff      out  [WIDTH] a - b - b_in modulo 2^WIDTH
//   b_out     out  final borrow (unsigned underflow)
//   ovf       out  signed two's-complement overflow
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [WIDTH-1:0]   a_sr_q,    a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,    b_sr_d;
  logic [WIDTH-1:0]   diff_sr_q, diff_sr_d;
  logic               borrow_q,  borrow_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   diff_q,    diff_d;
  logic               b_out_q,   b_out_d;
  logic               ovf_q,     ovf_d;

  // Full-subtractor slice applied to the current LSBs of the shift registers
  logic sub_a, sub_b, sub_bit, sub_borrow;

  always_comb begin
    sub_a      = a_sr_q[0];
    sub_b      = b_sr_q[0];
    sub_bit    = sub_a ^ sub_b ^ borrow_q;
    sub_borrow = (~sub_a & sub_b) | (~sub_a & borrow_q) | (sub_b & borrow_q);
  end

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    b_out_d   = b_out_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d    = a;
          b_sr_d    = b;
          borrow_d  = b_in;
          diff_sr_d = '0;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end

      RUN: begin
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        borrow_d  = sub_borrow;
        diff_sr_d = {sub_bit, diff_sr_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // The last slice processes the operand MSBs, so the sign-overflow
          // test can be made here without keeping copies of the operands.
          // The visible result registers change only on this edge, so they
          // hold their previous values for the rest of the operation.
          diff_d  = {sub_bit, diff_sr_q[WIDTH-1:1]};
          b_out_d = sub_borrow;
          ovf_d   = (sub_a != sub_b) & (sub_bit != sub_a);
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      b_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      b_out_q   <= b_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Scoreboard bench for serial_subtractor with WIDTH = 8.
//            The stimulus side pushes the arithmetic expectation for every
//            accepted operation. A negedge monitor checks each delivered
//            result and also checks that the result holds still while the
//            output handshake is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         b_out;
  logic         ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic rnd_rdy  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference model built on integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin, input int acc);
    exp_t e;
    int   ua, ub, sa, sbv, r;
    ua    = int'(ma);
    ub    = int'(mb);
    sa    = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sbv   = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    r     = sa - sbv - int'(mbin);
    e.d   = W'((ua - ub - int'(mbin) + 2**W) % (2**W));
    e.bo  = (ua < ub + int'(mbin));
    e.ov  = (r < -(2**(W-1))) || (r > 2**(W-1) - 1);
    e.acc = acc;
    return e;
  endfunction

  // Call this task at posedge+1.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    int n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      fail_now("send_wait_in_ready");
    end else begin
      a = ta; b = tb_; b_in = tbin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back(model(ta, tb_, tbin, cyc));
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0 || !in_ready) fail_now("drain");
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) fail_now("wait_out_valid");
  endtask

  // Monitor process
  logic prev_ov = 1'b0;
  logic post_hs = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (post_hs) check("valid_drops_after_handshake", 32'(out_valid), 32'd0);
      post_hs = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          if (!prev_ov) check("latency", 32'(cyc - sb[0].acc), 32'(W));
          check("in_ready_low_in_done", 32'(in_ready), 32'd0);
          if (out_ready) begin
            check("diff",  32'(diff),  32'(sb[0].d));
            check("b_out", 32'(b_out), 32'(sb[0].bo));
            check("ovf",   32'(ovf),   32'(sb[0].ov));
            void'(sb.pop_front());
            post_hs = 1'b1;
          end else begin
            check("diff_hold", 32'(diff), 32'(sb[0].d));
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // Random output back-pressure during the random phase
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_b_out",     32'(b_out),     32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    send(8'h05, 8'h03, 1'b0); wait_drain();
    send(8'h03, 8'h05, 1'b0); wait_drain();
    send(8'h00, 8'h00, 1'b1); wait_drain();
    send(8'h80, 8'h01, 1'b0); wait_drain();

    // Back-pressure: hold DONE for 5 cycles and try to inject a new operation
    out_ready = 1'b0;
    send(8'hC3, 8'h5A, 1'b1);
    wait_out_valid();
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_handshake_in_ready",  32'(in_ready),  32'd1);
    check("idle_after_handshake_out_valid", 32'(out_valid), 32'd0);
    send(8'h40, 8'hC0, 1'b0);     // back-to-back operation
    wait_drain();

    // Inputs change and in_valid pulses during RUN cycle 3
    send(8'h9C, 8'h27, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'hFF; b = 8'h00; b_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // Leave non-zero result registers behind, then reset during RUN cycle 4
    send(8'h7F, 8'hFF, 1'b0); wait_drain();
    send(8'h12, 8'h34, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_diff",      32'(diff),      32'd0);
    check("async_rst_b_out",     32'(b_out),     32'd0);
    check("async_rst_ovf",       32'(ovf),       32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h0A, 8'h0A, 1'b0); wait_drain();

    // Random phase with random back-pressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
